// File: rtl/z88_rtc.sv
// rtl/z88_rtc.sv - Z88 real-time clock: 5 ms tick, second/minute counters, sticky maskable interrupts.
// Serves ports $D0-$D4 and $B4/$B5; a $D0 read snapshots tim1/timm for coherent multi-byte reads.
module z88_rtc #(
  parameter int CLK_DIV       = 49152,
  parameter int TICKS_PER_SEC = 200,
  parameter int MIN_WIDTH     = 21,
  parameter int TICK_SRC      = 0
) (
  input  logic       mck,
  input  logic       rin,
  input  logic       tick,
  input  logic       restim,
  input  logic       io_wr,
  input  logic       io_rd,
  input  logic [7:0] addr,
  input  logic [7:0] wdata,
  output logic [7:0] rdata,
  output logic       irq
);

  localparam int PW = 20;
  localparam logic [PW-1:0] DIV_MAX = PW'(CLK_DIV - 1);
  localparam logic [7:0]    T0_MAX  = 8'(TICKS_PER_SEC - 1);

  logic [PW-1:0]        presc_q, presc_d;
  logic [2:0]           sync_q, sync_d;
  logic                 xpulse_q, xpulse_d;
  logic [7:0]           tim0_q, tim0_d;
  logic [5:0]           tim1_q, tim1_d, sh_tim1_q, sh_tim1_d;
  logic [MIN_WIDTH-1:0] timm_q, timm_d, sh_timm_q, sh_timm_d;
  logic [2:0]           tsta_q, tsta_d, tmk_q, tmk_d;
  logic [7:0]           rdata_q, rdata_d;

  logic tick_int, tick_ev, sec_ev, min_ev, wr_b4, wr_b5, snap;
  logic [23:0] sh_timm_ext;
  logic unused_wdata;

  assign unused_wdata = ^wdata[7:3];

  always_comb begin
    tick_int = (presc_q == DIV_MAX);
    tick_ev  = ~restim & ((TICK_SRC != 0) ? xpulse_q : tick_int);
    sec_ev   = tick_ev & (tim0_q == T0_MAX);
    min_ev   = sec_ev & (tim1_q == 6'd59);
    wr_b4    = io_wr & (addr == 8'hB4);
    wr_b5    = io_wr & (addr == 8'hB5);
    snap     = io_rd & ~io_wr & (addr == 8'hD0);
    sh_timm_ext = '0;
    sh_timm_ext[MIN_WIDTH-1:0] = sh_timm_q;
  end

  // Counters and prescaler; restim forces everything in the count path to 0.
  always_comb begin
    presc_d  = tick_int ? '0 : presc_q + PW'(1);
    sync_d   = {sync_q[1:0], tick};
    xpulse_d = sync_q[1] & ~sync_q[2];
    tim0_d   = tim0_q;
    tim1_d   = tim1_q;
    timm_d   = timm_q;
    if (tick_ev) tim0_d = sec_ev ? 8'd0 : tim0_q + 8'd1;
    if (sec_ev)  tim1_d = min_ev ? 6'd0 : tim1_q + 6'd1;
    if (min_ev)  timm_d = timm_q + MIN_WIDTH'(1);
    if (restim) begin
      presc_d  = '0;
      sync_d   = '0;
      xpulse_d = 1'b0;
      tim0_d   = '0;
      tim1_d   = '0;
      timm_d   = '0;
    end
  end

  // Set beats clear when an event and a tack hit the same bit together.
  always_comb begin
    tsta_d    = (tsta_q & ~(wr_b4 ? wdata[2:0] : 3'b000)) | {min_ev, sec_ev, tick_ev};
    tmk_d     = wr_b5 ? wdata[2:0] : tmk_q;
    sh_tim1_d = snap ? tim1_q : sh_tim1_q;
    sh_timm_d = snap ? timm_q : sh_timm_q;
    rdata_d   = rdata_q;
    if (io_rd) begin
      rdata_d = 8'h00;
      if (!io_wr) begin
        case (addr)
          8'hD0:   rdata_d = tim0_q;
          8'hD1:   rdata_d = {2'b00, sh_tim1_q};
          8'hD2:   rdata_d = sh_timm_ext[7:0];
          8'hD3:   rdata_d = sh_timm_ext[15:8];
          8'hD4:   rdata_d = sh_timm_ext[23:16];
          8'hB5:   rdata_d = {5'b00000, tsta_q};
          default: rdata_d = 8'h00;
        endcase
      end
    end
  end

  always_ff @(posedge mck or posedge rin) begin
    if (rin) begin
      presc_q   <= '0;
      sync_q    <= '0;
      xpulse_q  <= 1'b0;
      tim0_q    <= '0;
      tim1_q    <= '0;
      timm_q    <= '0;
      sh_tim1_q <= '0;
      sh_timm_q <= '0;
      tsta_q    <= '0;
      tmk_q     <= '0;
      rdata_q   <= '0;
    end else begin
      presc_q   <= presc_d;
      sync_q    <= sync_d;
      xpulse_q  <= xpulse_d;
      tim0_q    <= tim0_d;
      tim1_q    <= tim1_d;
      timm_q    <= timm_d;
      sh_tim1_q <= sh_tim1_d;
      sh_timm_q <= sh_timm_d;
      tsta_q    <= tsta_d;
      tmk_q     <= tmk_d;
      rdata_q   <= rdata_d;
    end
  end

  assign rdata = rdata_q;
  assign irq   = |(tsta_q & tmk_q);

endmodule

// File: tb/tb_z88_rtc.sv
// tb/tb_z88_rtc.sv - Scoreboard bench for z88_rtc; four instances share the bus with different parameters.
module tb_z88_rtc;

  logic mck = 1'b0;
  logic rin = 1'b1;
  logic tick = 1'b0, restim = 1'b0, io_wr = 1'b0, io_rd = 1'b0;
  logic [7:0] addr = 8'h00, wdata = 8'h00;
  logic [7:0] rdata_a, rdata_b, rdata_c, rdata_d;
  logic irq_a, irq_b, irq_c, irq_d;

  logic [7:0] exp_q[$];
  logic [7:0] e;
  int n_chk = 0;
  int n_fail = 0;

  always #5 mck = ~mck;

  z88_rtc #(.CLK_DIV(4), .TICKS_PER_SEC(4), .MIN_WIDTH(8), .TICK_SRC(0)) dut_a (
    .mck(mck), .rin(rin), .tick(tick), .restim(restim), .io_wr(io_wr), .io_rd(io_rd),
    .addr(addr), .wdata(wdata), .rdata(rdata_a), .irq(irq_a));
  z88_rtc #(.CLK_DIV(2), .TICKS_PER_SEC(4), .MIN_WIDTH(21), .TICK_SRC(0)) dut_b (
    .mck(mck), .rin(rin), .tick(tick), .restim(restim), .io_wr(io_wr), .io_rd(io_rd),
    .addr(addr), .wdata(wdata), .rdata(rdata_b), .irq(irq_b));
  z88_rtc #(.CLK_DIV(4), .TICKS_PER_SEC(8), .MIN_WIDTH(8), .TICK_SRC(1)) dut_c (
    .mck(mck), .rin(rin), .tick(tick), .restim(restim), .io_wr(io_wr), .io_rd(io_rd),
    .addr(addr), .wdata(wdata), .rdata(rdata_c), .irq(irq_c));
  z88_rtc #(.CLK_DIV(2), .TICKS_PER_SEC(2), .MIN_WIDTH(8), .TICK_SRC(0)) dut_d (
    .mck(mck), .rin(rin), .tick(tick), .restim(restim), .io_wr(io_wr), .io_rd(io_rd),
    .addr(addr), .wdata(wdata), .rdata(rdata_d), .irq(irq_d));

  task automatic run(input int n);
    repeat (n) begin
      @(posedge mck);
      #1;
    end
  endtask

  // After this returns, the next rising edge is edge 1 of the new run.
  task automatic reset_all();
    run(1);
    rin = 1'b1;
    run(2);
    rin = 1'b0;
  endtask

  task automatic wr(input logic [7:0] a, input logic [7:0] d);
    io_wr = 1'b1; addr = a; wdata = d;
    run(1);
    io_wr = 1'b0;
  endtask

  task automatic rd(input logic [7:0] a, input logic [7:0] expv);
    exp_q.push_back(expv);
    io_rd = 1'b1; addr = a;
    run(1);
    io_rd = 1'b0;
  endtask

  task automatic test_reset();
    reset_all();
    wr(8'hB5, 8'h07);
    run(9);
    rd(8'hD0, 8'h02);
    n_chk++; e = exp_q.pop_front();
    if (rdata_a !== e) begin n_fail++; $display("FAIL rst_pre_d0 got=%h exp=%h", rdata_a, e); end
    n_chk++; if (irq_a !== 1'b1) begin n_fail++; $display("FAIL rst_pre_irq got=%b exp=1", irq_a); end
    #2 rin = 1'b1;
    #1;
    n_chk++; if (rdata_a !== 8'h00) begin n_fail++; $display("FAIL rst_async_rdata got=%h exp=00", rdata_a); end
    n_chk++; if (irq_a !== 1'b0) begin n_fail++; $display("FAIL rst_async_irq got=%b exp=0", irq_a); end
    run(1);
    rin = 1'b0;
    rd(8'hB5, 8'h00);
    n_chk++; e = exp_q.pop_front();
    if (rdata_a !== e) begin n_fail++; $display("FAIL rst_tsta got=%h exp=%h", rdata_a, e); end
    n_chk++; if (irq_a !== 1'b0) begin n_fail++; $display("FAIL rst_irq got=%b exp=0", irq_a); end
    rd(8'hD0, 8'h00);
    n_chk++; e = exp_q.pop_front();
    if (rdata_a !== e) begin n_fail++; $display("FAIL rst_d0_e2 got=%h exp=%h", rdata_a, e); end
    run(1);
    rd(8'hD0, 8'h00);
    n_chk++; e = exp_q.pop_front();
    if (rdata_a !== e) begin n_fail++; $display("FAIL rst_d0_e4 got=%h exp=%h", rdata_a, e); end
    rd(8'hD0, 8'h01);
    n_chk++; e = exp_q.pop_front();
    if (rdata_a !== e) begin n_fail++; $display("FAIL rst_d0_e5 got=%h exp=%h", rdata_a, e); end
  endtask

  task automatic test_cascade();
    logic [7:0] addrs [6];
    logic [7:0] exps  [6];
    addrs = '{8'hD0, 8'hD1, 8'hD2, 8'hD3, 8'hD4, 8'hB5};
    exps  = '{8'h00, 8'h00, 8'h01, 8'h00, 8'h00, 8'h07};
    reset_all();
    run(480);
    for (int i = 0; i < 6; i++) begin
      rd(addrs[i], exps[i]);
      n_chk++; e = exp_q.pop_front();
      if (rdata_b !== e) begin n_fail++; $display("FAIL cascade_%h got=%h exp=%h", addrs[i], rdata_b, e); end
    end
  endtask

  // Edge 480 carries the tick that rolls tim0=3, tim1=59 into a new minute.
  task automatic test_snapshot();
    logic [7:0] addrs [6];
    logic [7:0] exps  [6];
    addrs = '{8'hD0, 8'hD1, 8'hD2, 8'hD0, 8'hD1, 8'hD2};
    exps  = '{8'h03, 8'h3B, 8'h00, 8'h01, 8'h00, 8'h01};
    reset_all();
    run(479);
    for (int i = 0; i < 6; i++) begin
      rd(addrs[i], exps[i]);
      n_chk++; e = exp_q.pop_front();
      if (rdata_b !== e) begin n_fail++; $display("FAIL snap_%0d_%h got=%h exp=%h", i, addrs[i], rdata_b, e); end
    end
  endtask

  task automatic test_irq();
    reset_all();
    wr(8'hB5, 8'h02);
    run(6);
    n_chk++; if (irq_b !== 1'b0) begin n_fail++; $display("FAIL irq_before_sec got=%b exp=0", irq_b); end
    run(1);
    n_chk++; if (irq_b !== 1'b1) begin n_fail++; $display("FAIL irq_sec got=%b exp=1", irq_b); end
    run(7);
    wr(8'hB4, 8'h02);
    n_chk++; if (irq_b !== 1'b1) begin n_fail++; $display("FAIL irq_tack_vs_event got=%b exp=1", irq_b); end
    wr(8'hB4, 8'h02);
    n_chk++; if (irq_b !== 1'b0) begin n_fail++; $display("FAIL irq_tack got=%b exp=0", irq_b); end
    rd(8'hB5, 8'h01);
    n_chk++; e = exp_q.pop_front();
    if (rdata_b !== e) begin n_fail++; $display("FAIL irq_tsta got=%h exp=%h", rdata_b, e); end
    wr(8'hB5, 8'h01);
    n_chk++; if (irq_b !== 1'b1) begin n_fail++; $display("FAIL irq_tmk got=%b exp=1", irq_b); end
    io_rd = 1'b1; io_wr = 1'b1; addr = 8'hB5; wdata = 8'h00;
    exp_q.push_back(8'h00);
    run(1);
    io_rd = 1'b0; io_wr = 1'b0;
    n_chk++; e = exp_q.pop_front();
    if (rdata_b !== e || irq_b !== 1'b0) begin
      n_fail++; $display("FAIL rdwr_same got=%h/%b exp=%h/0", rdata_b, irq_b, e);
    end
  endtask

  task automatic pulse_tick();
    tick = 1'b1;
    run(3);
    tick = 1'b0;
    run(3);
  endtask

  task automatic test_ext_restim();
    reset_all();
    for (int i = 0; i < 5; i++) pulse_tick();
    run(2);
    rd(8'hD0, 8'h05);
    n_chk++; e = exp_q.pop_front();
    if (rdata_c !== e) begin n_fail++; $display("FAIL ext_count got=%h exp=%h", rdata_c, e); end
    rd(8'hB5, 8'h01);
    n_chk++; e = exp_q.pop_front();
    if (rdata_c !== e) begin n_fail++; $display("FAIL ext_tsta got=%h exp=%h", rdata_c, e); end
    restim = 1'b1; tick = 1'b1;
    run(2);
    tick = 1'b0;
    run(1);
    restim = 1'b0;
    run(4);
    rd(8'hD0, 8'h00);
    n_chk++; e = exp_q.pop_front();
    if (rdata_c !== e) begin n_fail++; $display("FAIL restim_tim0 got=%h exp=%h", rdata_c, e); end
    rd(8'hB5, 8'h01);
    n_chk++; e = exp_q.pop_front();
    if (rdata_c !== e) begin n_fail++; $display("FAIL restim_tsta got=%h exp=%h", rdata_c, e); end
    pulse_tick();
    run(1);
    rd(8'hD0, 8'h01);
    n_chk++; e = exp_q.pop_front();
    if (rdata_c !== e) begin n_fail++; $display("FAIL restim_resume got=%h exp=%h", rdata_c, e); end
  endtask

  // dut_d: one minute is 240 edges, so the 256th minute lands on edge 61440.
  task automatic test_wrap();
    logic [7:0] addrs [3];
    logic [7:0] exps  [3];
    addrs = '{8'hD0, 8'hD2, 8'hB5};
    exps  = '{8'h00, 8'h00, 8'h07};
    reset_all();
    run(61420);
    wr(8'hB4, 8'h07);
    run(9);
    rd(8'hB5, 8'h03);
    n_chk++; e = exp_q.pop_front();
    if (rdata_d !== e) begin n_fail++; $display("FAIL wrap_tsta_pre got=%h exp=%h", rdata_d, e); end
    rd(8'hD0, 8'h01);
    n_chk++; e = exp_q.pop_front();
    if (rdata_d !== e) begin n_fail++; $display("FAIL wrap_d0_pre got=%h exp=%h", rdata_d, e); end
    rd(8'hD2, 8'hFF);
    n_chk++; e = exp_q.pop_front();
    if (rdata_d !== e) begin n_fail++; $display("FAIL wrap_timm_pre got=%h exp=%h", rdata_d, e); end
    run(7);
    for (int i = 0; i < 3; i++) begin
      rd(addrs[i], exps[i]);
      n_chk++; e = exp_q.pop_front();
      if (rdata_d !== e) begin n_fail++; $display("FAIL wrap_%h got=%h exp=%h", addrs[i], rdata_d, e); end
    end
  endtask

  initial begin
    test_reset();
    test_cascade();
    test_snapshot();
    test_irq();
    test_ext_restim();
    test_wrap();
    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
